// File: rtl/mic_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mic_sched_pkg
// Brief    : Shared FSM encoding and sizing helper for mic_sample_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mic_sched_pkg;

    localparam int unsigned c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so every counter has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mic_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : mic_tick_gen
// Brief    : Free-running SAMPLE_PERIOD counter; tick on the final count.
// Revision : 1.0 - initial release
// ============================================================================
module mic_tick_gen
    import mic_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 2000
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int unsigned          c_CNT_W = clog2(SAMPLE_PERIOD);
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(SAMPLE_PERIOD - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_wrap;

    assign w_wrap = (r_count == c_LAST);

    always_ff @(posedge clock) begin
        if (!resetn || !enable || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign tick = enable && w_wrap;

endmodule
`default_nettype wire

// File: rtl/mic_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mic_sample_scheduler
// Brief    : Paces PmodMIC acquisitions and packs samples into AXIS frames.
//            Optional capture watchdog enabled by MIC_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mic_sample_scheduler
    import mic_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned SAMPLE_PERIOD  = 2000,
    parameter int unsigned FRAME_LEN      = 256,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    enable,
    output logic                    mic_ready,
    input  logic                    mic_valid,
    input  logic [SAMPLE_WIDTH-1:0] mic_data,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [SAMPLE_WIDTH-1:0] m_axis_data,
    output logic                    m_axis_last,
    output logic [CNT_WIDTH-1:0]    overrun_count,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned        c_IDX_W    = clog2(FRAME_LEN);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(FRAME_LEN - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_tick;
    logic                     w_capture;
    logic                     w_accept;
    logic                     w_clear_idx;
    logic                     w_overrun;
    logic [SAMPLE_WIDTH-1:0]  r_data;
    logic                     r_last;
    logic [c_IDX_W-1:0]       r_idx;
    logic [CNT_WIDTH-1:0]     r_overrun;

    mic_tick_gen #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_tick_gen (
        .clock  (clock),
        .resetn (resetn),
        .enable (enable),
        .tick   (w_tick)
    );

`ifdef MIC_SCHED_TIMEOUT_EN
    localparam int unsigned        c_TO_W    = clog2(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_cap_cnt;
    logic              r_timeout_err;
    logic              w_timeout;

    assign w_timeout = (r_state == ST_CAP) && !mic_valid && (r_cap_cnt == c_TO_LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cap_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_CAP && !w_timeout) begin
                r_cap_cnt <= r_cap_cnt + c_TO_W'(1);
            end else begin
                r_cap_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Watchdog absent: CAP waits forever and the flag is constant low.
    assign timeout_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_clear_idx  = 1'b0;
        mic_ready    = 1'b0;
        m_axis_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (enable) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b0;
                if (w_tick) begin
                    w_state_nxt = ST_REQ;
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_clear_idx = 1'b1;
                end
            end
            ST_REQ: begin
                mic_ready   = 1'b1;
                w_state_nxt = ST_CAP;
            end
            ST_CAP: begin
                // Completes even with enable low: the sampler is mid-transfer.
                if (mic_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUT;
                end
`ifdef MIC_SCHED_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = ST_WAIT;
                end
`endif
            end
            ST_OUT: begin
                m_axis_valid = 1'b1;
                if (m_axis_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_overrun = w_tick &&
                       (r_state == ST_REQ || r_state == ST_CAP || r_state == ST_OUT);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_data    <= '0;
            r_last    <= 1'b0;
            r_idx     <= '0;
            r_overrun <= '0;
        end else begin
            if (w_capture) begin
                r_data <= mic_data;
                r_last <= (r_idx == c_IDX_LAST);
            end
            if (w_accept) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end else if (w_clear_idx) begin
                r_idx <= '0;
            end
            if (w_overrun && (r_overrun != {CNT_WIDTH{1'b1}})) begin
                r_overrun <= r_overrun + CNT_WIDTH'(1);
            end
        end
    end

    assign m_axis_data   = r_data;
    assign m_axis_last   = r_last;
    assign overrun_count = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mic_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_sample_scheduler
// Brief    : Table-driven, scoreboarded bench for mic_sample_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_sample_scheduler;

    localparam int c_SW  = 16;
    localparam int c_PER = 20;
    localparam int c_FL  = 4;
    localparam int c_CW  = 16;

    logic              clock        = 1'b0;
    logic              resetn       = 1'b0;
    logic              enable       = 1'b0;
    logic              mic_valid    = 1'b0;
    logic [c_SW-1:0]   mic_data     = '0;
    logic              m_axis_ready = 1'b1;
    logic              mic_ready;
    logic              m_axis_valid;
    logic [c_SW-1:0]   m_axis_data;
    logic              m_axis_last;
    logic [c_CW-1:0]   overrun_count;
    logic              busy;
    logic              timeout_err;

    mic_sample_scheduler #(
        .SAMPLE_WIDTH   (c_SW),
        .SAMPLE_PERIOD  (c_PER),
        .FRAME_LEN      (c_FL),
        .CNT_WIDTH      (c_CW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .mic_ready     (mic_ready),
        .mic_valid     (mic_valid),
        .mic_data      (mic_data),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data   (m_axis_data),
        .m_axis_last   (m_axis_last),
        .overrun_count (overrun_count),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [c_SW-1:0] data;
        logic            last;
    } exp_t;

    typedef struct {
        logic [c_SW-1:0] data;
        int              stall;
        bit              drop;
        int              gap;
        int              ovr;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[15];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mic_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t            v;
        exp_t            e;
        bit              ok;
        bit              hold_ok;
        int              exp_idx;
        int              ref_cyc;
        logic [c_SW-1:0] held_d;
        logic            held_l;

        vecs[0]  = '{16'h1234, 0,  1'b0, 20, 0};
        vecs[1]  = '{16'hFFFF, 0,  1'b0, 20, 0};
        vecs[2]  = '{16'h0000, 0,  1'b0, 20, 0};
        vecs[3]  = '{16'hA5A5, 0,  1'b0, 20, 0};
        vecs[4]  = '{16'h5A5A, 0,  1'b0, 20, 0};
        vecs[5]  = '{16'h8001, 45, 1'b0, 20, 2};
        vecs[6]  = '{16'h7FFE, 0,  1'b0, 60, 2};
        vecs[7]  = '{16'h0F0F, 0,  1'b0, 20, 2};
        vecs[8]  = '{16'hF0F0, 0,  1'b0, 20, 2};
        vecs[9]  = '{16'h1357, 0,  1'b0, 20, 2};
        vecs[10] = '{16'h2468, 0,  1'b1, 20, 2};
        vecs[11] = '{16'hDEAD, 0,  1'b0, 20, 2};
        vecs[12] = '{16'hBEEF, 3,  1'b0, 20, 2};
        vecs[13] = '{16'hCAFE, 0,  1'b0, 20, 2};
        vecs[14] = '{16'hF00D, 0,  1'b0, 20, 2};

        exp_idx = 0;

        // Reset state
        repeat (3) step();
        check("rst_valid",   m_axis_valid,  0);
        check("rst_ready",   mic_ready,     0);
        check("rst_busy",    busy,          0);
        check("rst_data",    m_axis_data,   0);
        check("rst_last",    m_axis_last,   0);
        check("rst_overrun", overrun_count, 0);
        check("rst_timeout", timeout_err,   0);

        // Stray mic_valid outside CAP must be ignored
        resetn    = 1'b1;
        mic_valid = 1'b1;
        mic_data  = 16'h4321;
        step();
        mic_valid = 1'b0;
        step();
        check("stray_valid", m_axis_valid, 0);
        check("stray_data",  m_axis_data,  0);

        enable  = 1'b1;
        ref_cyc = cyc;

        for (int r = 0; r < 15; r++) begin
            v = vecs[r];
            m_axis_ready = (v.stall == 0);
            wait_req(ok);
            if (!ok) check("req_timeout", 0, 1);
            check("req_gap",  cyc - ref_cyc, v.gap);
            check("req_busy", busy, 1);
            ref_cyc = cyc;
            step();
            check("req_single", mic_ready, 0);
            if (v.drop) enable = 1'b0;
            repeat (4) step();
            mic_valid = 1'b1;
            mic_data  = v.data;
            exp_q.push_back('{v.data, (exp_idx == c_FL - 1)});
            step();
            mic_valid = 1'b0;
            mic_data  = ~v.data;
            wait_valid(ok);
            if (!ok) check("valid_timeout", 0, 1);
            if (v.stall > 0) begin
                hold_ok = 1'b1;
                held_d  = m_axis_data;
                held_l  = m_axis_last;
                repeat (v.stall - 1) begin
                    step();
                    if (!m_axis_valid || m_axis_data !== held_d || m_axis_last !== held_l)
                        hold_ok = 1'b0;
                end
                check("hold_stable", hold_ok, 1);
                m_axis_ready = 1'b1;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", m_axis_data, e.data);
                check("out_last", m_axis_last, e.last);
            end else begin
                check("scoreboard_empty", 0, 1);
            end
            step();
            check("valid_drop", m_axis_valid, 0);
            exp_idx = (exp_idx == c_FL - 1) ? 0 : exp_idx + 1;
            check("overrun", overrun_count, v.ovr);
            if (v.drop) begin
                step();
                step();
                check("drop_busy",  busy,         0);
                check("drop_valid", m_axis_valid, 0);
                exp_idx = 0;
                enable  = 1'b1;
                ref_cyc = cyc;
            end
        end

        // Reset while a sample is held on the output
        m_axis_ready = 1'b0;
        wait_req(ok);
        if (!ok) check("req_timeout", 0, 1);
        repeat (5) step();
        mic_valid = 1'b1;
        mic_data  = 16'hC3C3;
        step();
        mic_valid = 1'b0;
        wait_valid(ok);
        if (!ok) check("valid_timeout", 0, 1);
        check("pre_rst_data", m_axis_data, 16'hC3C3);
        resetn = 1'b0;
        step();
        check("mid_rst_valid",   m_axis_valid,  0);
        check("mid_rst_ready",   mic_ready,     0);
        check("mid_rst_data",    m_axis_data,   0);
        check("mid_rst_last",    m_axis_last,   0);
        check("mid_rst_overrun", overrun_count, 0);
        check("mid_rst_busy",    busy,          0);
        check("mid_rst_timeout", timeout_err,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
